// File: rtl/ped_audio_gen.sv
// Accessible pedestrian signal audio stage: rapid burst tone during WALK,
// slow (mutable) locator tick during DON'T WALK, silence otherwise.
module ped_audio_gen #(
    parameter int TONE_HALF   = 2,
    parameter int WALK_ON     = 10,
    parameter int WALK_PERIOD = 25,
    parameter int LOC_ON      = 4,
    parameter int LOC_PERIOD  = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       walk,
    input  logic       no_walk,
    input  logic       mute,
    output logic       spk,
    output logic       env,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOCATE = 2'b01,
        WALK   = 2'b10
    } state_t;

    localparam logic [15:0] WALK_LAST = 16'(WALK_PERIOD - 1);
    localparam logic [15:0] LOC_LAST  = 16'(LOC_PERIOD - 1);
    localparam logic [15:0] WALK_ONW  = 16'(WALK_ON);
    localparam logic [15:0] LOC_ONW   = 16'(LOC_ON);
    localparam logic [15:0] TONE_LAST = 16'(TONE_HALF - 1);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        tone_q, tone_d;
    logic        state_change;
    logic        burst;

    always_comb begin
        state_d = IDLE;
        if (walk) begin
            state_d = WALK;
        end else if (no_walk && !mute) begin
            state_d = LOCATE;
        end
        state_change = (state_d != state_q);

        // Any state change restarts the pattern so the first burst is full length
        phase_d = '0;
        if (!state_change) begin
            case (state_q)
                WALK:    phase_d = (phase_q == WALK_LAST) ? 16'd0 : phase_q + 16'd1;
                LOCATE:  phase_d = (phase_q == LOC_LAST) ? 16'd0 : phase_q + 16'd1;
                default: phase_d = '0;
            endcase
        end

        burst = ((state_q == WALK) && (phase_q < WALK_ONW)) ||
                ((state_q == LOCATE) && (phase_q < LOC_ONW));

        tcnt_d = '0;
        tone_d = 1'b0;
        if (burst && !state_change) begin
            if (tcnt_q == TONE_LAST) begin
                tone_d = ~tone_q;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
                tone_d = tone_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            tcnt_q  <= '0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tcnt_q  <= tcnt_d;
            tone_q  <= tone_d;
        end
    end

    // Gating with burst keeps a stale tone from leaking past the envelope edge
    assign spk  = tone_q & burst;
    assign env  = burst;
    assign mode = state_q;

endmodule

// File: tb/tb_ped_audio_gen.sv
// Scoreboard bench for ped_audio_gen: a default instance and a continuous-tone
// instance (WALK_ON == WALK_PERIOD), both checked against a timing model.
module tb_ped_audio_gen;

    localparam int TH   = 2;
    localparam int LON  = 4;
    localparam int LPER = 100;
    localparam int WON_A = 10, WPER_A = 25;
    localparam int WON_B = 25, WPER_B = 25;

    logic clock = 1'b0;
    logic reset, walk, no_walk, mute;
    logic       spk_a, env_a, spk_b, env_b;
    logic [1:0] mode_a, mode_b;

    typedef struct packed {
        logic       spk;
        logic       env;
        logic [1:0] mode;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } exp_pair_t;

    exp_pair_t exp_q[$];
    exp_pair_t cur;
    int        m_mode[2];
    int        m_cnt[2];
    int        checks = 0;
    int        fails = 0;

    always #5 clock = ~clock;

    ped_audio_gen #(.TONE_HALF(TH), .WALK_ON(WON_A), .WALK_PERIOD(WPER_A),
                    .LOC_ON(LON), .LOC_PERIOD(LPER)) dut (
        .clock(clock), .reset(reset), .walk(walk), .no_walk(no_walk), .mute(mute),
        .spk(spk_a), .env(env_a), .mode(mode_a));

    ped_audio_gen #(.TONE_HALF(TH), .WALK_ON(WON_B), .WALK_PERIOD(WPER_B),
                    .LOC_ON(LON), .LOC_PERIOD(LPER)) dut_cont (
        .clock(clock), .reset(reset), .walk(walk), .no_walk(no_walk), .mute(mute),
        .spk(spk_b), .env(env_b), .mode(mode_b));

    // Expected outputs from the time spent in the current mode
    function automatic exp_t predict(int m, int cnt, int won, int wper);
        exp_t r;
        int on, per, p, q;
        r.mode = 2'(m);
        r.env  = 1'b0;
        r.spk  = 1'b0;
        if (m == 0) return r;
        on  = (m == 2) ? won : LON;
        per = (m == 2) ? wper : LPER;
        p = cnt % per;
        q = (on == per) ? cnt : p;
        r.env = (p < on);
        r.spk = r.env && (((q / TH) % 2) == 1);
        return r;
    endfunction

    task automatic applyStimulus(input logic r, input logic w, input logic nw, input logic mu);
        exp_pair_t e;
        int nm;
        @(negedge clock);
        reset = r; walk = w; no_walk = nw; mute = mu;
        nm = r ? 0 : (w ? 2 : ((nw && !mu) ? 1 : 0));
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = (nm != m_mode[d]) ? 0 : m_cnt[d] + 1;
            m_mode[d] = nm;
        end
        e.a = predict(m_mode[0], m_cnt[0], WON_A, WPER_A);
        e.b = predict(m_mode[1], m_cnt[1], WON_B, WPER_B);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, act, expv);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                checkOutput("spk_a",  {1'b0, spk_a}, {1'b0, cur.a.spk});
                checkOutput("env_a",  {1'b0, env_a}, {1'b0, cur.a.env});
                checkOutput("mode_a", mode_a,        cur.a.mode);
                checkOutput("spk_b",  {1'b0, spk_b}, {1'b0, cur.b.spk});
                checkOutput("env_b",  {1'b0, env_b}, {1'b0, cur.b.env});
                checkOutput("mode_b", mode_b,        cur.b.mode);
            end
        end
    end

    initial begin
        logic w, nw, mu;
        int   len;
        reset = 1'b1; walk = 1'b1; no_walk = 1'b0; mute = 1'b0;
        m_mode = '{0, 0};
        m_cnt  = '{0, 0};

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 60; i++) applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 210; i++) applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 1);

        for (int s = 0; s < 50; s++) begin
            w   = ($urandom_range(0, 2) == 0);
            nw  = ($urandom_range(0, 1) == 1);
            mu  = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 120);
            if ($urandom_range(0, 9) == 0) applyStimulus(1, w, nw, mu);
            for (int i = 0; i < len; i++) applyStimulus(0, w, nw, mu);
        end

        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
